// File: rtl/mmu_pkg.sv
// Shared definitions for the two-level MMU: address field widths, the TLB
// entry layout and the tree-PLRU helpers used by every associative array.
package mmu_pkg;

  localparam int PAGE_BITS = 12;
  localparam int PCID_W    = 12;
  localparam int VPN_W     = 64 - PAGE_BITS;
  localparam int PPN_W     = 64 - PAGE_BITS;

  // The PLRU helpers work on the largest supported tree (8 ways, 3 levels);
  // smaller arrays zero-extend their tree and pass the number of levels.
  localparam int PLRU_MAX_LEVELS = 3;
  localparam int PLRU_MAX_BITS   = 7;

  typedef struct packed {
    logic              valid;
    logic [PCID_W-1:0] pcid;
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
  } tlb_entry_t;

  // Node n has children 2n+1 (left) and 2n+2 (right). A node bit of 0 means
  // the next victim lies in the left subtree; touching a way points every
  // node on its path away from it.
  function automatic logic [PLRU_MAX_BITS-1:0] plruTouch(
    input logic [PLRU_MAX_BITS-1:0]   tree,
    input logic [PLRU_MAX_LEVELS-1:0] way,
    input int                         levels
  );
    logic [PLRU_MAX_BITS-1:0]   treeNext;
    logic [PLRU_MAX_LEVELS-1:0] path;
    logic [2:0]                 node;
    treeNext = tree;
    path     = way << (PLRU_MAX_LEVELS - levels);
    node     = '0;
    for (int lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        treeNext[node] = ~path[PLRU_MAX_LEVELS-1];
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, path[PLRU_MAX_LEVELS-1]};
        path = path << 1;
      end
    end
    return treeNext;
  endfunction

  function automatic logic [PLRU_MAX_LEVELS-1:0] plruVictim(
    input logic [PLRU_MAX_BITS-1:0] tree,
    input int                       levels
  );
    logic [PLRU_MAX_LEVELS-1:0] way;
    logic [2:0]                 node;
    logic                       dir;
    way  = '0;
    node = '0;
    for (int lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        dir  = tree[node];
        way  = {way[PLRU_MAX_LEVELS-2:0], dir};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
      end
    end
    return way;
  endfunction

endpackage

// File: rtl/mmu_two_level_tlb_array.sv
// Set-associative translation array with per-set tree-PLRU. With WAYS equal
// to ENTRIES it degenerates into a single fully-associative set.
module tlb_array
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int WAYS    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [PCID_W-1:0] pcid_i,
  input  logic [VPN_W-1:0]  vpn_i,
  input  logic              touch_i,
  input  logic              write_i,
  input  logic [PPN_W-1:0]  ppn_i,
  input  logic              inval_i,
  output logic              hit_o,
  output logic [PPN_W-1:0]  ppn_o
);

  localparam int SETS      = ENTRIES / WAYS;
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int SET_BITS  = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int TREE_BITS = WAYS - 1;

  tlb_entry_t           entry_q [SETS][WAYS];
  logic [TREE_BITS-1:0] plru_q  [SETS];

  logic [SET_BITS-1:0]  setIdx;
  logic [WAY_BITS-1:0]  hitWay;
  logic [WAY_BITS-1:0]  freeWay;
  logic [WAY_BITS-1:0]  victimWay;
  logic [WAY_BITS-1:0]  writeWay;
  logic                 freeFound;
  logic [TREE_BITS-1:0] plruHit_d;
  logic [TREE_BITS-1:0] plruWrite_d;

  assign setIdx = (SETS > 1) ? vpn_i[SET_BITS-1:0] : '0;

  // Tag compare across the indexed set; the lookup and the write share a key.
  always_comb begin
    hit_o  = 1'b0;
    ppn_o  = '0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (entry_q[setIdx][w].valid && entry_q[setIdx][w].pcid == pcid_i &&
          entry_q[setIdx][w].vpn == vpn_i) begin
        hit_o  = 1'b1;
        ppn_o  = entry_q[setIdx][w].ppn;
        hitWay = WAY_BITS'(w);
      end
    end
  end

  // Write slot: matching entry, else lowest invalid way, else PLRU victim.
  always_comb begin
    freeFound = 1'b0;
    freeWay   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!entry_q[setIdx][w].valid) begin
        freeFound = 1'b1;
        freeWay   = WAY_BITS'(w);
      end
    end
    victimWay = WAY_BITS'(plruVictim(PLRU_MAX_BITS'(plru_q[setIdx]), WAY_BITS));
    if (hit_o) begin
      writeWay = hitWay;
    end else if (freeFound) begin
      writeWay = freeWay;
    end else begin
      writeWay = victimWay;
    end
    plruHit_d   = TREE_BITS'(plruTouch(PLRU_MAX_BITS'(plru_q[setIdx]),
                                       PLRU_MAX_LEVELS'(hitWay), WAY_BITS));
    plruWrite_d = TREE_BITS'(plruTouch(PLRU_MAX_BITS'(plru_q[setIdx]),
                                       PLRU_MAX_LEVELS'(writeWay), WAY_BITS));
  end

  // Flush beats invalidate, which beats any write carrying the same key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) entry_q[s][w] <= '0;
      end
    end else if (flush_i) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) entry_q[s][w] <= '0;
      end
    end else if (inval_i) begin
      if (hit_o) begin
        entry_q[setIdx][hitWay].valid <= 1'b0;
        if (touch_i) plru_q[setIdx] <= plruHit_d;
      end
    end else if (write_i) begin
      entry_q[setIdx][writeWay] <= '{valid: 1'b1, pcid: pcid_i, vpn: vpn_i, ppn: ppn_i};
      plru_q[setIdx]            <= plruWrite_d;
    end else if (touch_i && hit_o) begin
      plru_q[setIdx] <= plruHit_d;
    end
  end

endmodule

// File: rtl/mmu_two_level.sv
// Two-level translation unit: a fully-associative L1 TLB refilled from a
// set-associative STLB, registered lookup response and PMU event counters.
module mmu_two_level
  import mmu_pkg::*;
#(
  parameter int L1_ENTRIES = 8,
  parameter int STLB_SETS  = 16,
  parameter int STLB_WAYS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shutdown,
  input  logic              tlb_insert,
  input  logic              stlb_insert,
  input  logic              validate,
  input  logic [63:0]       va,
  input  logic [63:0]       pa,
  input  logic [PCID_W-1:0] pcid,
  output logic [63:0]       ta,
  output logic              tlb_hit,
  output logic              stlb_hit,
  output logic              miss,
  output logic [63:0]       stat_hit,
  output logic [63:0]       stat_miss,
  output logic [63:0]       stat_prefetch
);

  logic [VPN_W-1:0] vpn;
  logic [PPN_W-1:0] insPpn;
  logic             l1Hit, stlbHit, refill;
  logic [PPN_W-1:0] l1Ppn, stlbPpn;
  logic             unusedPaOffset;

  logic [63:0] ta_q, ta_d;
  logic        tlbHit_q, tlbHit_d, stlbHit_q, stlbHit_d, miss_q, miss_d;
  logic [63:0] statHit_q, statHit_d, statMiss_q, statMiss_d, statPre_q, statPre_d;

  assign vpn            = va[63:PAGE_BITS];
  assign insPpn         = pa[63:PAGE_BITS];
  assign unusedPaOffset = ^pa[PAGE_BITS-1:0];
  assign refill         = !l1Hit && stlbHit;

  tlb_array #(.ENTRIES(L1_ENTRIES), .WAYS(L1_ENTRIES)) u_l1 (
    .clk(clk), .rst_n(rst_n), .flush_i(shutdown),
    .pcid_i(pcid), .vpn_i(vpn), .touch_i(1'b1),
    .write_i(tlb_insert || refill), .ppn_i(tlb_insert ? insPpn : stlbPpn),
    .inval_i(validate), .hit_o(l1Hit), .ppn_o(l1Ppn)
  );

  tlb_array #(.ENTRIES(STLB_SETS * STLB_WAYS), .WAYS(STLB_WAYS)) u_stlb (
    .clk(clk), .rst_n(rst_n), .flush_i(shutdown),
    .pcid_i(pcid), .vpn_i(vpn), .touch_i(!l1Hit),
    .write_i(stlb_insert), .ppn_i(insPpn),
    .inval_i(validate), .hit_o(stlbHit), .ppn_o(stlbPpn)
  );

  // Pick the response for this cycle's lookup and advance the event counters.
  always_comb begin
    ta_d      = '0;
    tlbHit_d  = 1'b0;
    stlbHit_d = 1'b0;
    miss_d    = 1'b0;
    if (!shutdown) begin
      if (l1Hit) begin
        ta_d     = {l1Ppn, va[PAGE_BITS-1:0]};
        tlbHit_d = 1'b1;
      end else if (stlbHit) begin
        ta_d      = {stlbPpn, va[PAGE_BITS-1:0]};
        stlbHit_d = 1'b1;
      end else begin
        miss_d = 1'b1;
      end
    end
    statHit_d  = statHit_q + 64'(tlbHit_q);
    statMiss_d = statMiss_q + 64'(miss_q);
    statPre_d  = statPre_q + 64'(tlb_insert || stlb_insert);
  end

  // Response and counter registers; counters survive shutdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ta_q       <= '0;
      tlbHit_q   <= 1'b0;
      stlbHit_q  <= 1'b0;
      miss_q     <= 1'b0;
      statHit_q  <= '0;
      statMiss_q <= '0;
      statPre_q  <= '0;
    end else begin
      ta_q       <= ta_d;
      tlbHit_q   <= tlbHit_d;
      stlbHit_q  <= stlbHit_d;
      miss_q     <= miss_d;
      statHit_q  <= statHit_d;
      statMiss_q <= statMiss_d;
      statPre_q  <= statPre_d;
    end
  end

  assign ta            = ta_q;
  assign tlb_hit       = tlbHit_q;
  assign stlb_hit      = stlbHit_q;
  assign miss          = miss_q;
  assign stat_hit      = statHit_q;
  assign stat_miss     = statMiss_q;
  assign stat_prefetch = statPre_q;

endmodule

// File: tb/tb_mmu_two_level.sv
// Directed bench for mmu_two_level with hand-computed translations and a
// small counter model driven by the expected response of each cycle.
module tb_mmu_two_level;

  typedef enum int {KIND_NONE, KIND_TLB, KIND_STLB, KIND_MISS} kind_e;

  localparam logic [63:0] VA_HI = 64'hFFFF_FFFF_FFFF_FFF1;

  logic        clk = 1'b0;
  logic        rst_n, shutdown, tlb_insert, stlb_insert, validate;
  logic [63:0] va, pa;
  logic [11:0] pcid;
  logic [63:0] ta, stat_hit, stat_miss, stat_prefetch;
  logic        tlb_hit, stlb_hit, miss;

  int          testCount = 0;
  int          failCount = 0;
  kind_e       prevKind;
  logic [63:0] expHit, expMiss, expPre;

  mmu_two_level dut (
    .clk(clk), .rst_n(rst_n), .shutdown(shutdown), .tlb_insert(tlb_insert),
    .stlb_insert(stlb_insert), .validate(validate), .va(va), .pa(pa),
    .pcid(pcid), .ta(ta), .tlb_hit(tlb_hit), .stlb_hit(stlb_hit), .miss(miss),
    .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_prefetch(stat_prefetch)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%h, expected 0x%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, and advance the counter model.
  task automatic applyStimulus(input logic ins1, input logic ins2, input logic inv,
                               input logic shut, input logic [11:0] p,
                               input logic [63:0] v, input logic [63:0] a,
                               input kind_e expKind);
    tlb_insert  = ins1;
    stlb_insert = ins2;
    validate    = inv;
    shutdown    = shut;
    pcid        = p;
    va          = v;
    pa          = a;
    @(posedge clk);
    if (prevKind == KIND_TLB)  expHit  = expHit + 64'd1;
    if (prevKind == KIND_MISS) expMiss = expMiss + 64'd1;
    if (ins1 || ins2)          expPre  = expPre + 64'd1;
    prevKind = expKind;
    #1;
  endtask

  task automatic checkLookup(input string tag, input kind_e expKind, input logic [63:0] expTa);
    logic [63:0] expFlags;
    case (expKind)
      KIND_TLB:  expFlags = 64'b100;
      KIND_STLB: expFlags = 64'b010;
      KIND_MISS: expFlags = 64'b001;
      default:   expFlags = 64'b000;
    endcase
    checkOutput({tag, "_ta"}, ta, expTa);
    checkOutput({tag, "_flags"}, {61'b0, tlb_hit, stlb_hit, miss}, expFlags);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_stat_hit"}, stat_hit, expHit);
    checkOutput({tag, "_stat_miss"}, stat_miss, expMiss);
    checkOutput({tag, "_stat_prefetch"}, stat_prefetch, expPre);
  endtask

  task automatic lookup(input string tag, input logic [11:0] p, input logic [63:0] v,
                        input kind_e expKind, input logic [63:0] expTa);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, p, v, 64'd0, expKind);
    checkLookup(tag, expKind, expTa);
  endtask

  // Watchdog so a stuck run still reports and ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time %0t, limit 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario: empty misses, PCID isolation, refill, invalidate, flush, reset.
  initial begin
    rst_n = 1'b0; shutdown = 1'b0; tlb_insert = 1'b0; stlb_insert = 1'b0;
    validate = 1'b0; va = '0; pa = '0; pcid = '0;
    prevKind = KIND_NONE; expHit = '0; expMiss = '0; expPre = '0;

    #12;
    checkLookup("reset", KIND_NONE, 64'd0);
    checkCounters("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) lookup("empty_miss", 12'd0, VA_HI, KIND_MISS, 64'd0);
    checkOutput("empty_stat_miss_const", stat_miss, 64'd2);
    checkCounters("empty");

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'd0, VA_HI, 64'd0, KIND_NONE);
    checkLookup("shutdown1", KIND_NONE, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, VA_HI, 64'd0, KIND_MISS);
    checkLookup("insert_c1", KIND_MISS, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, VA_HI, 64'd0, KIND_TLB);
    checkLookup("insert_c2", KIND_TLB, 64'h0000_0000_0000_0FF1);
    lookup("after_insert", 12'd0, VA_HI, KIND_TLB, 64'h0000_0000_0000_0FF1);
    checkOutput("prefetch_const", stat_prefetch, 64'd2);

    for (int i = 0; i < 4; i++) begin
      lookup("pcid1", 12'd1, VA_HI, KIND_MISS, 64'd0);
      lookup("pcid0", 12'd0, VA_HI, KIND_TLB, 64'h0000_0000_0000_0FF1);
    end
    checkCounters("pcid");

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 64'd0, 64'd0, KIND_NONE);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 64'(k) << 12,
                    64'(k + 256) << 12, KIND_MISS);
      checkLookup("fill", KIND_MISS, 64'd0);
    end
    lookup("k0_stlb", 12'd0, 64'h0, KIND_STLB, 64'h10_0000);
    lookup("k0_refilled", 12'd0, 64'h0, KIND_TLB, 64'h10_0000);
    lookup("k8_l1", 12'd0, 64'h8000, KIND_TLB, 64'h10_8000);
    lookup("k4_evicted", 12'd0, 64'h4000, KIND_STLB, 64'h10_4000);
    checkCounters("fill");

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 64'h3000, 64'd0, KIND_TLB);
    checkLookup("validate_cycle", KIND_TLB, 64'h10_3000);
    lookup("k3_invalid", 12'd0, 64'h3000, KIND_MISS, 64'd0);
    lookup("k7_still", 12'd0, 64'h7000, KIND_TLB, 64'h10_7000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 64'h5000, 64'h99_9000, KIND_TLB);
    checkLookup("validate_vs_insert", KIND_TLB, 64'h10_5000);
    lookup("k5_invalid", 12'd0, 64'h5000, KIND_MISS, 64'd0);
    lookup("k1_still", 12'd0, 64'h1abc, KIND_TLB, 64'h10_1abc);
    checkCounters("validate");

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 64'h7000, 64'd0, KIND_NONE);
    checkLookup("shutdown2", KIND_NONE, 64'd0);
    lookup("k7_flushed", 12'd0, 64'h7000, KIND_MISS, 64'd0);
    lookup("k1_flushed", 12'd0, 64'h1000, KIND_MISS, 64'd0);
    checkCounters("after_flush");

    #2;
    rst_n = 1'b0;
    #1;
    checkLookup("async_reset", KIND_NONE, 64'd0);
    checkOutput("async_reset_stat_hit", stat_hit, 64'd0);
    checkOutput("async_reset_stat_miss", stat_miss, 64'd0);
    checkOutput("async_reset_stat_prefetch", stat_prefetch, 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
